// File: rtl/dualport_ram_writer_if.sv
// rtl/dualport_ram_writer_if.sv - load stream, status and dual read-port bundle for dualport_ram_writer
interface dualport_ram_writer_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
);
  logic              start;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              busy;
  logic              loaded;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] dout_a;
  logic [DATA_W-1:0] dout_b;

  modport master (
    output start, wr_valid, wr_data, a_addr, b_addr,
    input  wr_ready, busy, loaded, dout_a, dout_b
  );

  modport slave (
    input  start, wr_valid, wr_data, a_addr, b_addr,
    output wr_ready, busy, loaded, dout_a, dout_b
  );
endinterface

// File: rtl/dualport_ram_writer.sv
// rtl/dualport_ram_writer.sv - field-loadable dual-port table filled sequentially from a valid/ready stream
module dualport_ram_writer #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dualport_ram_writer_if.slave  bus
);
  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              loaded_q, loaded_d;
  logic              wr_accept;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] dout_a_q, dout_b_q;

  // Handshake is decoded from registered state only, so reset drops it at once.
  assign wr_accept    = bus.wr_valid && (state_q == LOAD);
  assign bus.wr_ready = (state_q == LOAD);
  assign bus.busy     = (state_q == LOAD);
  assign bus.loaded   = loaded_q;
  assign bus.dout_a   = dout_a_q;
  assign bus.dout_b   = dout_b_q;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    loaded_d = loaded_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d  = LOAD;
          wr_ptr_d = '0;
          loaded_d = 1'b0;
        end
      end
      LOAD: begin
        // start is deliberately ignored here; the running load keeps its pointer.
        if (wr_accept) begin
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          if (wr_ptr_q == LAST_ADDR) begin
            state_d  = DONE;
            loaded_d = 1'b1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        wr_ptr_d = '0;
        loaded_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      loaded_q <= loaded_d;
    end
  end

  // Table contents survive reset so a partially loaded table is still readable.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_q] <= bus.wr_data;
    end
  end

  // Non-blocking reads against the same edge's write give read-first behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_a_q <= '0;
      dout_b_q <= '0;
    end else begin
      dout_a_q <= mem[bus.a_addr];
      dout_b_q <= mem[bus.b_addr];
    end
  end
endmodule

// File: tb/tb_dualport_ram_writer.sv
// tb/tb_dualport_ram_writer.sv - self-checking bench for dualport_ram_writer against a word-count model
module tb_dualport_ram_writer;
  localparam int DATA_W = 4;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  dualport_ram_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  dualport_ram_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 if (clk_en) clk = ~clk;

  // Model: a load is "count of words taken so far"; the next word lands at that count.
  logic [3:0] m_mem   [16];
  logic       m_known [16] = '{default: 1'b0};
  int         m_count;
  logic       m_loading, m_loaded;
  logic [3:0] m_dout_a, m_dout_b;
  logic       m_ka, m_kb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_loading <= 1'b0;
      m_loaded  <= 1'b0;
      m_count   <= 0;
      m_dout_a  <= 4'h0;
      m_dout_b  <= 4'h0;
      m_ka      <= 1'b1;
      m_kb      <= 1'b1;
    end else begin
      m_dout_a <= m_mem[bus.a_addr];
      m_ka     <= m_known[bus.a_addr];
      m_dout_b <= m_mem[bus.b_addr];
      m_kb     <= m_known[bus.b_addr];
      if (m_loading && bus.wr_valid) begin
        m_mem[m_count]   <= bus.wr_data;
        m_known[m_count] <= 1'b1;
        if (m_count == 15) begin
          m_loading <= 1'b0;
          m_loaded  <= 1'b1;
          m_count   <= 0;
        end else begin
          m_count <= m_count + 1;
        end
      end else if (!m_loading && bus.start) begin
        m_loading <= 1'b1;
        m_loaded  <= 1'b0;
        m_count   <= 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_wr_ready", 32'(bus.wr_ready), 32'(m_loading));
    check("model_busy",     32'(bus.busy),     32'(m_loading));
    check("model_loaded",   32'(bus.loaded),   32'(m_loaded));
    if (m_ka) check("model_dout_a", 32'(bus.dout_a), 32'(m_dout_a));
    if (m_kb) check("model_dout_b", 32'(bus.dout_b), 32'(m_dout_b));
  end

  function automatic logic [3:0] bp_word(input int i);
    return (i == 3) ? 4'hA : 4'((i + 7) & 15);
  endfunction

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drive_word(input logic [3:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 4'h0;
    bus.a_addr   = 4'h0;
    bus.b_addr   = 4'h0;
    #3;
    check("rst_dout_a",   32'(bus.dout_a),   0);
    check("rst_dout_b",   32'(bus.dout_b),   0);
    check("rst_wr_ready", 32'(bus.wr_ready), 0);
    check("rst_busy",     32'(bus.busy),     0);
    check("rst_loaded",   32'(bus.loaded),   0);

    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("idle_wr_ready", 32'(bus.wr_ready), 0);
    end
    bus.wr_valid = 1'b0;

    // Full back-to-back load of 15-i.
    pulse_start();
    check("start_ready", 32'(bus.wr_ready), 1);
    for (int i = 0; i < 16; i++) begin
      drive_word(4'(15 - i));
      if (i == 14) begin
        check("full_loaded_early", 32'(bus.loaded), 0);
        check("full_ready_early",  32'(bus.wr_ready), 1);
      end
    end
    check("full_loaded", 32'(bus.loaded), 1);
    check("full_ready_drop", 32'(bus.wr_ready), 0);
    bus.a_addr = 4'h0;
    bus.b_addr = 4'hF;
    @(negedge clk);
    check("full_a0", 32'(bus.dout_a), 32'hF);
    check("full_b15", 32'(bus.dout_b), 32'h0);
    for (int j = 0; j < 16; j++) begin
      bus.a_addr = 4'(j);
      bus.b_addr = 4'(15 - j);
      @(negedge clk);
      check("full_sweep_a", 32'(bus.dout_a), 32'(15 - j));
      check("full_sweep_b", 32'(bus.dout_b), 32'(j));
    end

    // Backpressure load with a collision at address 3 and a stray start.
    pulse_start();
    check("bp_loaded_clear", 32'(bus.loaded), 0);
    bus.a_addr = 4'h3;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      if (i == 4) check("collision_new", 32'(bus.dout_a), 32'hA);
      drive_word(bp_word(i));
      if (i == 3) check("collision_old", 32'(bus.dout_a), 32'hC);
    end
    check("bp_loaded", 32'(bus.loaded), 1);
    for (int j = 0; j < 16; j++) begin
      bus.a_addr = 4'(j);
      bus.b_addr = 4'(j);
      @(negedge clk);
      check("bp_sweep_a", 32'(bus.dout_a), 32'(bp_word(j)));
      check("bp_sweep_b", 32'(bus.dout_b), 32'(bp_word(j)));
    end

    // Reload with i; untouched addresses keep the previous table.
    pulse_start();
    check("reload_loaded_clear", 32'(bus.loaded), 0);
    bus.a_addr = 4'hA;
    bus.b_addr = 4'h3;
    for (int i = 0; i < 8; i++) drive_word(4'(i));
    check("reload_old_a10", 32'(bus.dout_a), 32'h1);
    check("reload_new_b3",  32'(bus.dout_b), 32'h3);
    for (int i = 8; i < 16; i++) drive_word(4'(i));
    check("reload_loaded", 32'(bus.loaded), 1);
    for (int j = 0; j < 16; j++) begin
      bus.a_addr = 4'(j);
      bus.b_addr = 4'(15 - j);
      @(negedge clk);
      check("reload_sweep_a", 32'(bus.dout_a), 32'(j));
      check("reload_sweep_b", 32'(bus.dout_b), 32'(15 - j));
    end

    // Reset after 7 writes, then a fresh load from address 0.
    pulse_start();
    for (int i = 0; i < 7; i++) drive_word(4'h9);
    check("midload_busy", 32'(bus.busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_wr_ready", 32'(bus.wr_ready), 0);
    check("async_busy",     32'(bus.busy),     0);
    check("async_loaded",   32'(bus.loaded),   0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    for (int i = 0; i < 16; i++) drive_word(4'((i + 3) & 15));
    check("rl_loaded", 32'(bus.loaded), 1);
    for (int j = 0; j < 16; j++) begin
      bus.a_addr = 4'(j);
      bus.b_addr = 4'(j);
      @(negedge clk);
      check("rl_sweep_a", 32'(bus.dout_a), 32'((j + 3) & 15));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dualport_ram_writer.md
# dualport_ram_writer

Writable counterpart to the team's 16x4 dual-port synchronous-read ROM. It accepts a stream of data words over a valid/ready handshake and writes them into consecutive addresses from 0 to DEPTH-1. Once every address is written it flags `loaded`. It has the same two independent registered read ports as the ROM, so downstream logic can use it as a drop-in, field-loadable replacement for the fixed-content table.

## Interface
- `DATA_W`, default 4, word width of each memory entry and read port.
- `ADDR_W`, default 4, address width. DEPTH = 2**ADDR_W, which is 16 by default.
- `clk`  in  1  single clock. All state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  single-cycle request to begin or restart a load at address 0.
- `wr_valid`  in  1  `wr_data` is valid this cycle.
- `wr_data`  in  DATA_W  word to be written at the current write pointer.
- `wr_ready`  out  1  block accepts a word this cycle. A write occurs when `wr_valid` and `wr_ready` are both high at a rising edge.
- `busy`  out  1  load in progress (state LOAD).
- `loaded`  out  1  all DEPTH addresses written since the last `start`.
- `a_addr`  in  ADDR_W  read port A address.
- `b_addr`  in  ADDR_W  read port B address.
- `dout_a`  out  DATA_W  registered read data, port A.
- `dout_b`  out  DATA_W  registered read data, port B.

## Operation
- **States.**
  - IDLE: after reset, waits for `start`.
  - LOAD: accepting words.
  - DONE: table complete.
- **Transitions.**
  - IDLE to LOAD on `start`.
  - LOAD to DONE on the accepted write at pointer DEPTH-1.
  - DONE to LOAD on `start` (reload).
  - `start` in LOAD is ignored. The load continues and the pointer is not reset.
- **Write pointer.**
  - ADDR_W bits, cleared to 0 on entry to LOAD.
  - Increments by 1 on each accepted write.
  - Wraps to 0 after DEPTH-1. This coincides with entry to DONE.
- **Handshake outputs.**
  - `wr_ready` = (state == LOAD) and `busy` = (state == LOAD). Both are decoded from registered state only, with no combinational path from `wr_valid` or `start`.
  - `wr_valid` while `wr_ready` is low is ignored and writes nothing.
- **`loaded`.**
  - Set at the edge that accepts the final write.
  - Cleared at the edge where `start` moves the FSM into LOAD.
  - Held otherwise.
- **Read ports.**
  - Each port registers mem[addr] on every rising edge, in every state, independently of the other port.
  - Both ports may read the same address.
- **Read/write collision.** A read and an accepted write to the same address at the same edge return the old contents (read-first).
- **Memory contents.**
  - Not reset. Contents persist across reset and across a reload until overwritten.
  - Addresses never written since power-up read undefined. The bench must not check them.
- **Reset (`rst_n` low, asynchronous).**
  - state = IDLE, write pointer = 0, `loaded` = 0, `dout_a` = `dout_b` = 0.
  - `wr_ready` = `busy` = 0 immediately, without waiting for a clock edge.
  - Reset mid-load abandons the load. Words already written remain in memory.

## Timing
- **`start` to ready.** `start` sampled at edge k puts the FSM in LOAD after k. `wr_ready` is high in cycle k+1, and the first write can be accepted at edge k+1.
- **Full load throughput.** One word per cycle. With `wr_valid` held high, the 16 writes land at edges k+1 to k+16. `loaded` goes high and `wr_ready` goes low after k+16.
- **Backpressure.** A low `wr_valid` cycle stalls the pointer. No write occurs and nothing else changes.
- **Read latency.** One cycle: an address presented before edge t appears on `dout_x` after edge t.
- **Write-to-read visibility.** A write accepted at edge t is visible on `dout_x` after edge t+1.

## Test plan
- **Reset values.** Assert `rst_n`=0 with no clock running. Required: `dout_a`=`dout_b`=0, `wr_ready`=`busy`=`loaded`=0. Release reset and hold idle for 5 cycles: all outputs stay unchanged and `wr_ready` stays 0 while `wr_valid`=1.
- **Full load and dual read.** Pulse `start`, then drive `wr_data`=15-i for i=0..15 back-to-back.
  - Required: `loaded`=1 exactly after the 16th accepted edge, and `wr_ready` drops at the same time.
  - Then `a_addr`=0, `b_addr`=15 gives `dout_a`=4'hF, `dout_b`=4'h0 one cycle later.
  - Then sweep all 16 addresses on both ports.
- **Backpressure.** During a load, deassert `wr_valid` on every other cycle. Required: 16 words are still written in order, with no skipped or duplicated addresses, and `loaded` asserts after the 16th accepted word.
- **Collision and `start` during LOAD.**
  - Write 4'hA to address 3 while `a_addr`=3 at the same edge. Required: `dout_a` shows the old value, then 4'hA one edge later.
  - Pulse `start` mid-load. Required: the pointer is unaffected.
- **Reload.** From DONE, pulse `start` and write the words i=0..15.
  - Required: `loaded` falls after the `start` edge.
  - Required: reads of addresses not yet rewritten return the previous load's values.
  - Final table reads dout=i.
- **Reset mid-load.** Drop `rst_n` after 7 writes.
  - Required: `wr_ready`, `busy` and `loaded` go to 0 asynchronously.
  - Then `start` and load again. The first write lands at address 0, and addresses 0..6 from the abandoned load are overwritten.
